// File: rtl/regbank_sb_pkg.sv
// regbank_sb shared types and constants.
// Address helpers used by the register bank and its forwarding muxes.
package regbank_sb_pkg;

    localparam int AW_MAX     = 5;
    localparam int NUM_REGS_I = 32;
    localparam int NUM_REGS_E = 16;

    typedef logic [AW_MAX-1:0] regaddr_t;

    localparam regaddr_t REG_ZERO = '0;

    function automatic logic is_zero(input regaddr_t a);
        return a == REG_ZERO;
    endfunction

endpackage

// File: rtl/regbank_sb_if.sv
// Decode/write-back bundle for the scoreboarded register bank.
// master = core pipeline side, slave = register bank.
interface regbank_sb_if
    import regbank_sb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = NUM_REGS_I,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][AW-1:0]   rs_i;
    logic [NUM_RD-1:0][XLEN-1:0] data_o;
    logic [NUM_RD-1:0]           busy_o;
    logic                        issue_i;
    logic [AW-1:0]               issue_rd_i;
    logic                        we0_i;
    logic [AW-1:0]               wa0_i;
    logic [XLEN-1:0]             wd0_i;
    logic                        we1_i;
    logic [AW-1:0]               wa1_i;
    logic [XLEN-1:0]             wd1_i;
    logic                        flush_i;
    logic                        conflict_o;

    modport master (
        output rs_i, issue_i, issue_rd_i,
        output we0_i, wa0_i, wd0_i,
        output we1_i, wa1_i, wd1_i, flush_i,
        input  data_o, busy_o, conflict_o
    );

    modport slave (
        input  rs_i, issue_i, issue_rd_i,
        input  we0_i, wa0_i, wd0_i,
        input  we1_i, wa1_i, wd1_i, flush_i,
        output data_o, busy_o, conflict_o
    );

endinterface

// File: rtl/regbank_sb_fwd.sv
// Per-read-port forwarding mux for regbank_sb.
// Forwards same-cycle writes only when REGBANK_BYPASS_EN is defined.
module regbank_sb_fwd
    import regbank_sb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   rs,
    input  logic [XLEN-1:0] arr_data,
    input  logic            arr_busy,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    output logic [XLEN-1:0] data,
    output logic            busy
);

`ifdef REGBANK_BYPASS_EN
    logic rz;
    logic hit0;
    logic hit1;
    logic hit_iss;

    assign rz      = is_zero(regaddr_t'(rs));
    assign hit0    = we0 && (wa0 == rs) && !rz;
    assign hit1    = we1 && (wa1 == rs) && !rz;
    assign hit_iss = issue && (issue_rd == rs);

    assign data = hit0 ? wd0 :
                  hit1 ? wd1 : arr_data;

    // A landing late result retires the pending write unless re-issued.
    assign busy = arr_busy && !(hit1 && !hit_iss);
`else
    logic unused_ok;

    assign unused_ok = ^{we0, wa0, wd0, we1, wa1, wd1,
                         issue, issue_rd, rs};
    assign data = arr_data;
    assign busy = arr_busy;
`endif

endmodule

// File: rtl/regbank_sb.sv
// Parametrised register bank with two write ports and RAW scoreboard.
// Define REGBANK_BYPASS_EN to forward same-cycle writes to the reads.
module regbank_sb
    import regbank_sb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = NUM_REGS_I,
    parameter int NUM_RD   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    regbank_sb_if.slave bus
);

    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                conflict;
    logic                wr0;
    logic                wr1;

    assign wr0 = bus.we0_i && !is_zero(regaddr_t'(bus.wa0_i));
    assign wr1 = bus.we1_i && !is_zero(regaddr_t'(bus.wa1_i));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy     <= '0;
            conflict <= 1'b0;
        end else begin
            // Port 0 is written last so it wins a same-address clash.
            if (wr1) regs[bus.wa1_i] <= bus.wd1_i;
            if (wr0) regs[bus.wa0_i] <= bus.wd0_i;
            conflict <= wr0 && wr1 && (bus.wa0_i == bus.wa1_i);
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.flush_i) begin
                    busy[r] <= 1'b0;
                end else if (bus.issue_i &&
                             bus.issue_rd_i == AW'(r)) begin
                    busy[r] <= 1'b1;
                end else if (wr1 && bus.wa1_i == AW'(r)) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign bus.conflict_o = conflict;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [XLEN-1:0] arr_data;
        logic            arr_busy;
        logic [XLEN-1:0] rd_data;
        logic            rd_busy;

        assign arr_data = regs[bus.rs_i[k]];
        assign arr_busy = busy[bus.rs_i[k]];

        regbank_sb_fwd #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_fwd (
            .rs       (bus.rs_i[k]),
            .arr_data (arr_data),
            .arr_busy (arr_busy),
            .we0      (bus.we0_i),
            .wa0      (bus.wa0_i),
            .wd0      (bus.wd0_i),
            .we1      (bus.we1_i),
            .wa1      (bus.wa1_i),
            .wd1      (bus.wd1_i),
            .issue    (bus.issue_i),
            .issue_rd (bus.issue_rd_i),
            .data     (rd_data),
            .busy     (rd_busy)
        );

        assign bus.data_o[k] = rd_data;
        assign bus.busy_o[k] = rd_busy;
    end

    a_issue_busy : assert property (
        @(posedge clk) disable iff (!reset_n)
        !(bus.issue_i && !bus.flush_i && busy[bus.issue_rd_i])
    );

endmodule

// File: tb/tb_regbank_sb.sv
// Bench for regbank_sb: directed table, corner sequences, random vs model.
// Covers a 32x2 instance and a 16x3 (RV32E-style) instance.
module tb_regbank_sb;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regbank_sb_if #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) bus0 ();
    regbank_sb_if #(.XLEN(32), .NUM_REGS(16), .NUM_RD(3)) bus1 ();

    regbank_sb #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) u0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    regbank_sb #(.XLEN(32), .NUM_REGS(16), .NUM_RD(3)) u1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] m  [32];
    logic        mb [32];
    logic        mconf;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic        cf;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.rs_i       = '0;
        bus0.issue_i    = 1'b0;
        bus0.issue_rd_i = '0;
        bus0.we0_i      = 1'b0;
        bus0.wa0_i      = '0;
        bus0.wd0_i      = '0;
        bus0.we1_i      = 1'b0;
        bus0.wa1_i      = '0;
        bus0.wd1_i      = '0;
        bus0.flush_i    = 1'b0;
    endtask

    task automatic idle1();
        bus1.rs_i       = '0;
        bus1.issue_i    = 1'b0;
        bus1.issue_rd_i = '0;
        bus1.we0_i      = 1'b0;
        bus1.wa0_i      = '0;
        bus1.wd0_i      = '0;
        bus1.we1_i      = 1'b0;
        bus1.wa1_i      = '0;
        bus1.wd1_i      = '0;
        bus1.flush_i    = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m[i]  = '0;
            mb[i] = 1'b0;
        end
        mconf = 1'b0;
    endtask

    function automatic logic [31:0] ref_rd(
        input logic [4:0] a,
        input logic w0, input logic [4:0] a0, input logic [31:0] d0,
        input logic w1, input logic [4:0] a1, input logic [31:0] d1);
        if (a == 0) return 32'h0;
        if (BYP && w0 && a0 == a) return d0;
        if (BYP && w1 && a1 == a) return d1;
        return m[a];
    endfunction

    function automatic logic ref_busy(
        input logic [4:0] a,
        input logic w1, input logic [4:0] a1,
        input logic iss, input logic [4:0] ird);
        if (a == 0) return 1'b0;
        return mb[a] && !(BYP && w1 && a1 == a && !(iss && ird == a));
    endfunction

    initial begin
        logic        w0, w1, iss, fl;
        logic [4:0]  a0, a1, ird, r0, r1;
        logic [31:0] d0, d1;

        idle0();
        idle1();
        model_clear();
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
        tick();

        // reset state on every address
        for (int a = 0; a < 32; a++) begin
            bus0.rs_i[0] = 5'(a);
            bus0.rs_i[1] = 5'(31 - a);
            #1;
            check("rst_d0", bus0.data_o[0], 32'h0);
            check("rst_d1", bus0.data_o[1], 32'h0);
            check("rst_b0", {31'h0, bus0.busy_o[0]}, 32'h0);
            check("rst_b1", {31'h0, bus0.busy_o[1]}, 32'h0);
        end
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < 3; k++) bus1.rs_i[k] = 4'(a);
            #1;
            for (int k = 0; k < 3; k++) begin
                check("rst16_d", bus1.data_o[k], 32'h0);
                check("rst16_b", {31'h0, bus1.busy_o[k]}, 32'h0);
            end
        end
        check("rst_conf", {31'h0, bus0.conflict_o}, 32'h0);
        idle0();
        tick();

        // same-cycle read of a fresh write
        bus0.we0_i   = 1'b1;
        bus0.wa0_i   = 5'd5;
        bus0.wd0_i   = 32'h1234_5678;
        bus0.rs_i[0] = 5'd5;
        bus0.rs_i[1] = 5'd5;
        #1;
        check("same_cyc_x5", bus0.data_o[0],
              BYP ? 32'h1234_5678 : 32'h0);
        tick();
        idle0();
        bus0.rs_i[0] = 5'd5;
        #1;
        check("next_cyc_x5", bus0.data_o[0], 32'h1234_5678);

        tbl[0]  = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,
                    0, 5, 0, 32'h12345678, 0, 0, 0};
        tbl[1]  = '{1, 6, 32'h11112222, 0, 0, 0, 0, 0, 0,
                    6, 0, 32'h11112222, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 7, 0,
                    7, 6, 0, 32'h11112222, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0,
                    7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0};
        tbl[4]  = '{1, 3, 32'h1, 1, 3, 32'h2, 0, 0, 0,
                    3, 3, 32'h1, 32'h1, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                    3, 7, 32'h1, 32'hA5A5A5A5, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 9, 32'h55, 1, 9, 0,
                    9, 0, 32'h55, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,
                    9, 9, 32'h55, 32'h55, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 11, 32'h77, 1, 10, 1,
                    10, 11, 0, 32'h77, 0, 0, 0};
        tbl[9]  = '{1, 12, 32'h0BAD, 0, 0, 0, 1, 12, 0,
                    12, 0, 32'h0BAD, 0, 1, 0, 0};
        tbl[10] = '{1, 12, 32'hC0DE, 0, 0, 0, 0, 0, 0,
                    12, 12, 32'hC0DE, 32'hC0DE, 1, 1, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 32'hFFFF, 1, 0, 0,
                    0, 12, 0, 32'hC0DE, 0, 1, 0};
        tbl[12] = '{1, 13, 32'h1, 1, 14, 32'h2, 0, 0, 0,
                    13, 14, 32'h1, 32'h2, 0, 0, 0};
        tbl[13] = '{1, 0, 32'h3, 1, 0, 32'h4, 0, 0, 0,
                    0, 12, 0, 32'hC0DE, 0, 1, 0};

        for (int i = 0; i < 14; i++) begin
            bus0.we0_i      = tbl[i].we0;
            bus0.wa0_i      = tbl[i].wa0;
            bus0.wd0_i      = tbl[i].wd0;
            bus0.we1_i      = tbl[i].we1;
            bus0.wa1_i      = tbl[i].wa1;
            bus0.wd1_i      = tbl[i].wd1;
            bus0.issue_i    = tbl[i].iss;
            bus0.issue_rd_i = tbl[i].ird;
            bus0.flush_i    = tbl[i].fl;
            tick();
            idle0();
            bus0.rs_i[0] = tbl[i].rs0;
            bus0.rs_i[1] = tbl[i].rs1;
            #1;
            check($sformatf("tbl%0d_d0", i), bus0.data_o[0], tbl[i].d0);
            check($sformatf("tbl%0d_d1", i), bus0.data_o[1], tbl[i].d1);
            check($sformatf("tbl%0d_b0", i),
                  {31'h0, bus0.busy_o[0]}, {31'h0, tbl[i].b0});
            check($sformatf("tbl%0d_b1", i),
                  {31'h0, bus0.busy_o[1]}, {31'h0, tbl[i].b1});
            check($sformatf("tbl%0d_cf", i),
                  {31'h0, bus0.conflict_o}, {31'h0, tbl[i].cf});
        end

        // 16-entry bank, three read ports
        tick();
        bus1.we0_i = 1'b1;
        bus1.wa0_i = 4'd15;
        bus1.wd0_i = 32'hCAFE_F00D;
        tick();
        idle1();
        for (int k = 0; k < 3; k++) bus1.rs_i[k] = 4'd15;
        bus1.issue_i    = 1'b1;
        bus1.issue_rd_i = 4'd15;
        bus0.we0_i = 1'b1;
        bus0.wa0_i = 5'd3;
        bus0.wd0_i = 32'h9;
        bus0.we1_i = 1'b1;
        bus0.wa1_i = 5'd3;
        bus0.wd1_i = 32'hA;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("e16_d%0d", k), bus1.data_o[k], 32'hCAFEF00D);
            check($sformatf("e16_b%0d", k), {31'h0, bus1.busy_o[k]}, 32'h0);
        end
        tick();
        idle0();
        idle1();
        for (int k = 0; k < 3; k++) bus1.rs_i[k] = 4'd15;
        bus0.rs_i[0] = 5'd3;
        bus0.rs_i[1] = 5'd7;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("e16_busy%0d", k), {31'h0, bus1.busy_o[k]}, 32'h1);
        check("pre_rst_conf", {31'h0, bus0.conflict_o}, 32'h1);
        check("pre_rst_x3", bus0.data_o[0], 32'h9);

        // asynchronous reset mid-sequence
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("mid_rst16_d", bus1.data_o[k], 32'h0);
            check("mid_rst16_b", {31'h0, bus1.busy_o[k]}, 32'h0);
        end
        check("mid_rst_x3", bus0.data_o[0], 32'h0);
        check("mid_rst_x7", bus0.data_o[1], 32'h0);
        check("mid_rst_conf", {31'h0, bus0.conflict_o}, 32'h0);
        #1;
        reset_n = 1'b1;
        model_clear();
        tick();

        // random traffic against the reference model
        for (int it = 0; it < 600; it++) begin
            if (it == 300) begin
                reset_n = 1'b0;
                #1;
                check("rnd_rst_d0", bus0.data_o[0], 32'h0);
                check("rnd_rst_b1", {31'h0, bus0.busy_o[1]}, 32'h0);
                check("rnd_rst_cf", {31'h0, bus0.conflict_o}, 32'h0);
                reset_n = 1'b1;
                model_clear();
            end
            w0  = 1'($urandom_range(0, 1));
            w1  = 1'($urandom_range(0, 1));
            a0  = $urandom_range(0, 1) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(0, 7));
            a1  = $urandom_range(0, 1) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(0, 7));
            d0  = $urandom;
            d1  = $urandom;
            fl  = ($urandom_range(0, 15) == 0);
            ird = 5'($urandom_range(0, 15));
            iss = 1'($urandom_range(0, 1)) && !mb[ird];
            r0  = $urandom_range(0, 1) ? a1 : 5'($urandom_range(0, 31));
            r1  = $urandom_range(0, 1) ? ird : 5'($urandom_range(0, 31));
            bus0.we0_i      = w0;
            bus0.wa0_i      = a0;
            bus0.wd0_i      = d0;
            bus0.we1_i      = w1;
            bus0.wa1_i      = a1;
            bus0.wd1_i      = d1;
            bus0.issue_i    = iss;
            bus0.issue_rd_i = ird;
            bus0.flush_i    = fl;
            bus0.rs_i[0]    = r0;
            bus0.rs_i[1]    = r1;
            #1;
            check("rnd_d0", bus0.data_o[0],
                  ref_rd(r0, w0, a0, d0, w1, a1, d1));
            check("rnd_d1", bus0.data_o[1],
                  ref_rd(r1, w0, a0, d0, w1, a1, d1));
            check("rnd_b0", {31'h0, bus0.busy_o[0]},
                  {31'h0, ref_busy(r0, w1, a1, iss, ird)});
            check("rnd_b1", {31'h0, bus0.busy_o[1]},
                  {31'h0, ref_busy(r1, w1, a1, iss, ird)});
            check("rnd_cf", {31'h0, bus0.conflict_o}, {31'h0, mconf});
            mconf = w0 && w1 && a0 == a1 && a0 != 0;
            if (w1 && a1 != 0) m[a1] = d1;
            if (w0 && a0 != 0) m[a0] = d0;
            if (fl) begin
                for (int r = 0; r < 32; r++) mb[r] = 1'b0;
            end else begin
                if (w1 && a1 != 0) mb[a1] = 1'b0;
                if (iss && ird != 0) mb[ird] = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regbank_sb.md
Name: regbank_sb

Overview:
- Parametrised successor of the core register bank.
- Configurable data width, register count (32 for RV32I, 16 for RV32E) and read-port count.
- Two write ports: port 0 is early ALU/CSR write-back; port 1 is late load/MUL-DIV write-back.
- Per-register scoreboard tracks pending writes so decode can stall on RAW hazards against long-latency results.
- Sits between decode (reads, issue) and the write-back stages of the core.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, register count; legal values 16 or 32; AW = $clog2(NUM_REGS)
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous active-low reset
rs_i  input  NUM_RD x AW  read addresses
data_o  output  NUM_RD x XLEN  read data
busy_o  output  NUM_RD  selected register has a pending write
issue_i  input  1  decode issues an instruction with a late-result destination
issue_rd_i  input  AW  destination marked busy on issue
we0_i  input  1  write enable, port 0
wa0_i  input  AW  write address, port 0
wd0_i  input  XLEN  write data, port 0
we1_i  input  1  write enable, port 1
wa1_i  input  AW  write address, port 1
wd1_i  input  XLEN  write data, port 1
flush_i  input  1  pipeline flush; clears all busy bits
conflict_o  output  1  registered; pulses one cycle after both write ports targeted the same nonzero register

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset: all registers 0, all busy bits 0, conflict_o 0. data_o and busy_o then read 0.
- Reads are combinational from the register array: data_o[k] = reg[rs_i[k]], busy_o[k] = busy[rs_i[k]].
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it are dropped, and issue to it is ignored.
- Writes: on the rising edge of clk, if weN_i and waN_i != 0, then reg[waN_i] <= wdN_i.
- Same-address simultaneous writes (nonzero address): port 0 wins. conflict_o = 1 on the next cycle, otherwise 0.
- Scoreboard, per register r != 0, next-state priority (highest first):
  - flush_i: busy <= 0 for all r. Writes in the same cycle still commit; issue_i in the same cycle is ignored.
  - issue_i and issue_rd_i == r: busy <= 1. This applies even if a write to r lands in the same cycle, because the new pending result is younger.
  - we1_i and wa1_i == r: busy <= 0.
  - Port 0 writes do not clear busy. Only late results are scoreboarded.
- Protocol: decode must not issue to a register that is already busy. A simulation assertion fires on violation.
- Read latency: 0 cycles from the array. A write becomes visible to reads on the cycle after the edge, unless the bypass option is compiled in.
- Reset mid-operation: asynchronous clear of all state. In-flight writes are lost.

Optional Feature:
- Macro REGBANK_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data: port 0 has priority over port 1, which has priority over the array.
  - busy_o[k] is forced to 0 when we1_i writes rs_i[k] in the same cycle and no issue targets it.
  - Address 0 is never bypassed.
- Undefined:
  - Pure array read, with one-cycle write-to-read visibility.
  - busy_o reflects only the registered busy bits.

Decomposition:
- Add to the core package:
  - a regaddr_t typedef of AW bits
  - the constants REG_ZERO and NUM_REGS_E = 16
- One natural sub-module, regbank_sb_fwd: a per-read-port forwarding mux. It is instantiated NUM_RD times and only contains logic when REGBANK_BYPASS_EN is defined.

Test Plan:
- Reset, then read all addresses: data_o = 0 and busy_o = 0 everywhere. Write x0 with 32'hDEADBEEF on port 0: it still reads 0.
- Write x5 = 32'h1234_5678 on port 0. Without bypass, a same-cycle read of x5 returns 0 and the next cycle returns 32'h1234_5678. With bypass, the same-cycle read returns 32'h1234_5678.
- Issue rd = x7: busy_o for x7 = 1 from the next cycle. Port 1 write of x7 = 32'hA5A5_A5A5: busy clears the next cycle and the data reads back.
- Port 0 writes x3 = 32'h1 and port 1 writes x3 = 32'h2 in the same cycle: x3 reads 32'h1 and conflict_o = 1 for exactly one cycle.
- Issue x9 and port 1 writes x9 in the same cycle: x9 stays busy. Flush with x9 busy: busy clears the next cycle and the register value is unchanged.
- NUM_REGS = 16 and NUM_RD = 3: write x15 = 32'hCAFE_F00D and read it on all three ports simultaneously. Assert reset mid-sequence: everything returns to 0.
